seq_checker_01246: RTL and testbench

SEQ_CHECKER_01246 -- requirements
Module: seq_checker_01246

---
 rtl/seq_checker_01246.sv | 153 +++++++++++++++
 tb/tb_seq_checker_01246.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_checker_01246.sv
// seq_checker_01246: lock-and-track checker for the 0,1,2,4,6 sequence counter.
// It acquires lock after LOCK_CNT consecutive correct samples and then counts
// mismatches (saturating) and 6->0 wraps (modulo 2^CNT_W) while locked.
// Optional feature macro: SEQ_CHK_STICKY_EN makes err_flag sticky until clear.
module seq_checker_01246 #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       counter_in,
    input  logic             clear,
    output logic             locked,
    output logic [2:0]       expected,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_LOCKING = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic             LOCK_NOW = (LOCK_CNT == 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [2:0] match_cnt;
    logic       sample_match;
    logic       lock_err;
    logic       lock_wrap;
    logic       lock_reached;

    // Successor of a legal sequence value; illegal inputs map to 0 (never used).
    function automatic logic [2:0] succ(input logic [2:0] v);
        logic [2:0] r;
        case (v)
            3'd0:    r = 3'd1;
            3'd1:    r = 3'd2;
            3'd2:    r = 3'd4;
            3'd4:    r = 3'd6;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    // Only 0,1,2,4,6 are produced by the upstream counter.
    function automatic logic is_legal(input logic [2:0] v);
        return (v == 3'd0) || (v == 3'd1) || (v == 3'd2) ||
               (v == 3'd4) || (v == 3'd6);
    endfunction

    assign sample_match = (counter_in == expected);
    assign lock_err     = en && (state == S_LOCKED) && !sample_match;
    assign lock_wrap    = en && (state == S_LOCKED) && sample_match &&
                          (counter_in == 3'd0);
    assign lock_reached = (({1'b0, match_cnt} + 4'd1) >= LOCK_TGT);

    // Acquisition FSM: seed, confirm LOCK_CNT samples, then track until a mismatch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SEARCH;
            match_cnt <= 3'd0;
            expected  <= 3'd0;
            locked    <= 1'b0;
        end else if (en) begin
            case (state)
                S_SEARCH: begin
                    if (is_legal(counter_in)) begin
                        expected  <= succ(counter_in);
                        match_cnt <= 3'd1;
                        state     <= LOCK_NOW ? S_LOCKED : S_LOCKING;
                        locked    <= LOCK_NOW;
                    end
                end
                S_LOCKING: begin
                    if (sample_match) begin
                        expected  <= succ(counter_in);
                        match_cnt <= match_cnt + 3'd1;
                        if (lock_reached) begin
                            state  <= S_LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (is_legal(counter_in)) begin
                        // Restart confirmation from this sample.
                        expected  <= succ(counter_in);
                        match_cnt <= 3'd1;
                    end else begin
                        match_cnt <= 3'd0;
                        state     <= S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    if (sample_match) begin
                        expected <= succ(counter_in);
                    end else begin
                        // The offending sample is not trusted as a new seed.
                        match_cnt <= 3'd0;
                        locked    <= 1'b0;
                        state     <= S_SEARCH;
                    end
                end
                default: begin
                    match_cnt <= 3'd0;
                    locked    <= 1'b0;
                    state     <= S_SEARCH;
                end
            endcase
        end
    end

    // Statistics counters; clear wins over a same-edge increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count  <= '0;
            wrap_count <= '0;
        end else if (clear) begin
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            if (lock_err && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end
            if (lock_wrap) begin
                wrap_count <= wrap_count + CNT_ONE;
            end
        end
    end

    // Error pulse and flag; the flag either mirrors the pulse or latches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            err_pulse <= lock_err;
`ifdef SEQ_CHK_STICKY_EN
            if (lock_err) begin
                err_flag <= 1'b1;
            end else if (clear) begin
                err_flag <= 1'b0;
            end
`else
            err_flag <= lock_err;
`endif
        end
    end

endmodule

// File: tb/tb_seq_checker_01246.sv
// Directed bench for seq_checker_01246: one DUT with CNT_W=8 and one with
// CNT_W=2, both driven by the same stimulus, checked with immediate assertions.
module tb_seq_checker_01246;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] counter_in;
    logic       clear;

    logic       locked, err_pulse, err_flag;
    logic [2:0] expected;
    logic [7:0] err_count, wrap_count;

    logic       locked2, err_pulse2, err_flag2;
    logic [2:0] expected2;
    logic [1:0] err_count2, wrap_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_checker_01246 #(.CNT_W(8), .LOCK_CNT(3)) dut (
        .clk(clk), .reset(reset), .en(en), .counter_in(counter_in), .clear(clear),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .err_flag(err_flag), .err_count(err_count), .wrap_count(wrap_count)
    );

    seq_checker_01246 #(.CNT_W(2), .LOCK_CNT(3)) dut2 (
        .clk(clk), .reset(reset), .en(en), .counter_in(counter_in), .clear(clear),
        .locked(locked2), .expected(expected2), .err_pulse(err_pulse2),
        .err_flag(err_flag2), .err_count(err_count2), .wrap_count(wrap_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic e, input logic [2:0] v, input logic c);
        en         = e;
        counter_in = v;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_expected"}, 32'(expected), 32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_wrap_count"}, 32'(wrap_count), 32'd0);
    endtask

    initial begin
        int w2[5] = '{2, 3, 0, 1, 2};
        int e2[5] = '{1, 2, 3, 3, 3};
        logic sticky_hold;
`ifdef SEQ_CHK_STICKY_EN
        sticky_hold = 1'b1;
`else
        sticky_hold = 1'b0;
`endif
        reset      = 1'b1;
        en         = 1'b0;
        counter_in = 3'd0;
        clear      = 1'b0;
        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Lock on 0,1,2, then track 4,6,0,1
        step(1, 3'd0, 0); chk("lk0_exp", 32'(expected), 1); chk("lk0_locked", 32'(locked), 0);
        step(1, 3'd1, 0); chk("lk1_exp", 32'(expected), 2); chk("lk1_locked", 32'(locked), 0);
        step(1, 3'd2, 0); chk("lk2_exp", 32'(expected), 4); chk("lk2_locked", 32'(locked), 1);
        step(1, 3'd4, 0); chk("trk4_exp", 32'(expected), 6);
        step(1, 3'd6, 0); chk("trk6_exp", 32'(expected), 0); chk("trk6_wrap", 32'(wrap_count), 0);
        step(1, 3'd0, 0); chk("trk0_wrap", 32'(wrap_count), 1); chk("trk0_exp", 32'(expected), 1);
        step(1, 3'd1, 0); chk("trk1_err", 32'(err_count), 0); chk("trk1_locked", 32'(locked), 1);

        // Inject 5 where 4 is expected, then relock
        step(1, 3'd2, 0); chk("pre5_exp", 32'(expected), 4);
        step(1, 3'd5, 0);
        chk("e5_pulse", 32'(err_pulse), 1);
        chk("e5_count", 32'(err_count), 1);
        chk("e5_locked", 32'(locked), 0);
        chk("e5_flag", 32'(err_flag), 1);
        chk("e5_exp_held", 32'(expected), 4);
        step(1, 3'd0, 0);
        chk("e5_pulse_end", 32'(err_pulse), 0);
        chk("e5_flag_after", 32'(err_flag), 32'(sticky_hold));
        chk("rs0_exp", 32'(expected), 1);
        step(1, 3'd1, 0);
        step(1, 3'd2, 0); chk("rs_locked", 32'(locked), 1); chk("rs_exp", 32'(expected), 4);
        if (sticky_hold) begin
            step(0, 3'd0, 1);
            chk("flag_cleared", 32'(err_flag), 0);
            chk("clr_err_count", 32'(err_count), 0);
            step(1, 3'd4, 0);
            step(1, 3'd6, 0);
            step(1, 3'd0, 0);
            step(1, 3'd1, 0);
            step(1, 3'd2, 0);
            chk("clr_relocked", 32'(locked), 1);
            chk("clr_wrap", 32'(wrap_count), 1);
        end

        // en=0 for 4 cycles: everything holds
        for (int i = 0; i < 4; i++) begin
            step(0, 3'd5, 0);
            chk("hold_locked", 32'(locked), 1);
            chk("hold_exp", 32'(expected), 4);
            chk("hold_pulse", 32'(err_pulse), 0);
        end
        step(1, 3'd4, 0); chk("resume_exp", 32'(expected), 6); chk("resume_locked", 32'(locked), 1);

        // Error on the same edge as clear: clear wins for the counters
        step(1, 3'd3, 1);
        chk("ec_pulse", 32'(err_pulse), 1);
        chk("ec_count", 32'(err_count), 0);
        chk("ec_wrap", 32'(wrap_count), 0);
        chk("ec_flag", 32'(err_flag), 1);
        chk("ec_locked", 32'(locked), 0);
        step(1, 3'd7, 0);
        chk("ec_flag_next", 32'(err_flag), 32'(sticky_hold));
        chk("ec_pulse_next", 32'(err_pulse), 0);
        step(0, 3'd0, 1);
        chk("ec_flag_clr", 32'(err_flag), 0);

        // In SEARCH: 3,7 ignored, 2 seeds, lock after 6
        step(1, 3'd3, 0); chk("s3_exp", 32'(expected), 6); chk("s3_pulse", 32'(err_pulse), 0);
        step(1, 3'd7, 0); chk("s7_exp", 32'(expected), 6); chk("s7_err", 32'(err_count), 0);
        step(1, 3'd2, 0); chk("s2_exp", 32'(expected), 4); chk("s2_locked", 32'(locked), 0);
        step(1, 3'd4, 0); chk("s4_locked", 32'(locked), 0);
        step(1, 3'd6, 0); chk("s6_locked", 32'(locked), 1); chk("s6_err", 32'(err_count), 0);
        chk("s6_exp", 32'(expected), 0);

        // Saturation / wrap rollover on the CNT_W=2 instance
        step(1, 3'd0, 0); chk("sat_w0", 32'(wrap_count2), 1);
        step(1, 3'd1, 0);
        step(1, 3'd2, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 3'd4, 0);
            step(1, 3'd6, 0);
            step(1, 3'd0, 0);
            chk("sat_wrap2", 32'(wrap_count2), 32'(w2[i]));
            chk("sat_wrap8", 32'(wrap_count), 32'(i + 2));
            step(1, 3'd3, 0);
            chk("sat_err2", 32'(err_count2), 32'(e2[i]));
            chk("sat_err8", 32'(err_count), 32'(i + 1));
            chk("sat_pulse2", 32'(err_pulse2), 1);
            step(1, 3'd0, 0);
            step(1, 3'd1, 0);
            step(1, 3'd2, 0);
            chk("sat_relock", 32'(locked2), 1);
        end

        // Asynchronous reset between edges while locked
        chk("ar_pre_locked", 32'(locked), 1);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        chk("async_reset_err2", 32'(err_count2), 0);
        #1;
        reset = 1'b0;
        step(1, 3'd0, 0); chk("post_exp", 32'(expected), 1); chk("post_locked", 32'(locked), 0);

        // LOCKING re-seed on a legal mismatch, lock sample does not count a wrap
        step(1, 3'd4, 0); chk("reseed_exp", 32'(expected), 6); chk("reseed_err", 32'(err_count), 0);
        step(1, 3'd6, 0); chk("reseed6_locked", 32'(locked), 0);
        step(1, 3'd0, 0); chk("reseed0_locked", 32'(locked), 1); chk("reseed0_wrap", 32'(wrap_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
